// File: rtl/odd_mult_pkg.sv
// Shared types and defaults for the sequential odd-element product block.
package odd_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEF = 5;
  localparam int W_DEF = 32;

  // Element index width; clamped to 1 so a single-element array still gets a real register.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/odd_mult_seq_if.sv
// Input/output valid-ready bundle between the array producer, the block and the result consumer.
interface odd_mult_seq_if
  import odd_mult_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
);
  localparam int CW = $clog2(N + 1);

  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] arr;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   result;
  logic [CW-1:0]  odd_count;
  logic           busy;

  modport master (
    output in_valid, arr, out_ready,
    input  in_ready, out_valid, result, odd_count, busy
  );

  modport slave (
    input  in_valid, arr, out_ready,
    output in_ready, out_valid, result, odd_count, busy
  );

endinterface

// File: rtl/odd_mult_step.sv
// One multiply-accumulate step: fold a single element into the running odd product and count.
module odd_mult_step
  import odd_mult_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = $clog2(N_DEF + 1)
) (
  input  logic [W-1:0]  acc,
  input  logic [W-1:0]  elem,
  input  logic [CW-1:0] cnt,
  output logic [W-1:0]  acc_next,
  output logic [CW-1:0] cnt_next
);

  // The low W bits of the full 2W-bit product equal a W-bit-wide multiply.
  logic [W-1:0] prod_lo;

  assign prod_lo  = acc * elem;
  assign acc_next = elem[0] ? prod_lo : acc;
  assign cnt_next = elem[0] ? cnt + CW'(1) : cnt;

endmodule

// File: rtl/odd_mult_seq.sv
// Sequential product of the odd elements of a packed array, one element per cycle.
module odd_mult_seq
  import odd_mult_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input logic          clk,
  input logic          rst,
  odd_mult_seq_if.slave bus
);

  localparam int IDX_W = idx_w(N);
  localparam int CW    = $clog2(N + 1);

  state_t         state_reg, state_next;
  logic [N*W-1:0] arr_reg;
  logic [W-1:0]   acc_reg, acc_next, result_reg;
  logic [CW-1:0]  cnt_reg, cnt_next, count_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [W-1:0]   elems [N];
  logic           last;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_elem
      assign elems[gi] = arr_reg[gi*W +: W];
    end
  endgenerate

  assign last = (idx_reg == IDX_W'(N - 1));

  odd_mult_step #(
    .W  (W),
    .CW (CW)
  ) u_step (
    .acc      (acc_reg),
    .elem     (elems[idx_reg]),
    .cnt      (cnt_reg),
    .acc_next (acc_next),
    .cnt_next (cnt_next)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (last)          state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arr_reg    <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      result_reg <= '0;
      count_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            arr_reg <= bus.arr;
            acc_reg <= W'(1);
            cnt_reg <= '0;
            idx_reg <= '0;
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_next;
          // Result registers only load on the final element, so they hold through DONE.
          if (last) begin
            result_reg <= acc_next;
            count_reg  <= cnt_next;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.result    = result_reg;
  assign bus.odd_count = count_reg;

endmodule

// File: tb/tb_odd_mult_seq.sv
// Self-checking bench: directed and random arrays against a modular-arithmetic reference model.
module tb_odd_mult_seq;
  import odd_mult_pkg::*;

  localparam int N  = N_DEF;
  localparam int W  = W_DEF;
  localparam int CW = $clog2(N + 1);

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  odd_mult_seq_if #(.N(N), .W(W)) bus ();

  odd_mult_seq #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Product taken modulo 2^W over every odd element, starting from 1.
  function automatic void model(input logic [N*W-1:0] a, output logic [W-1:0] r,
                                output logic [CW-1:0] c);
    longint unsigned p;
    longint unsigned e;
    int n;
    p = 1;
    n = 0;
    for (int i = 0; i < N; i++) begin
      e = {32'b0, a[i*W +: W]};
      if (e % 2 == 1) begin
        p = (p * e) % (64'd1 << W);
        n++;
      end
    end
    r = p[W-1:0];
    c = CW'(n);
  endfunction

  function automatic logic [N*W-1:0] rand_arr();
    logic [N*W-1:0] a;
    logic [W-1:0] e;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 3))
        0: e = '0;
        1: e = W'($urandom_range(1, 20));
        2: e = W'($urandom) & ~W'(1);
        default: e = W'($urandom) | W'(1);
      endcase
      a[i*W +: W] = e;
    end
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one array, wait for the result, return it and the accept-to-out_valid latency.
  task automatic do_txn(input logic [N*W-1:0] a, output int lat,
                        output logic [W-1:0] r, output logic [CW-1:0] c);
    int k;
    k = 0;
    while (!bus.in_ready && k < 100) begin
      step();
      k++;
    end
    bus.in_valid = 1'b1;
    bus.arr      = a;
    step();
    bus.in_valid = 1'b0;
    bus.arr      = {N{W'($urandom)}};
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      step();
      lat++;
    end
    if (k >= 100) lat = -1;
    r = bus.result;
    c = bus.odd_count;
    $display("[TB] txn arr=%h result=%h odd_count=%0d latency=%0d", a, r, c, lat);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.arr       = '0;
    step();
    step();
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl in_ready=%b out_valid=%b busy=%b required 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    tests_run++;
    if (bus.result !== '0 || bus.odd_count !== '0) begin
      tests_failed++;
      $display("FAIL reset_data result=%h odd_count=%0d required 0 0", bus.result, bus.odd_count);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_directed();
    logic [N*W-1:0] arrs [4];
    logic [W-1:0]   exp_r [4];
    logic [CW-1:0]  exp_c [4];
    logic [W-1:0]   r;
    logic [CW-1:0]  c;
    int lat;
    arrs[0] = {32'd9, 32'd7, 32'd5, 32'd3, 32'd1};         exp_r[0] = 32'd945;        exp_c[0] = 3'd5;
    arrs[1] = {32'd10, 32'd8, 32'd6, 32'd4, 32'd2};        exp_r[1] = 32'd1;          exp_c[1] = 3'd0;
    arrs[2] = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3};         exp_r[2] = 32'd105;        exp_c[2] = 3'd3;
    arrs[3] = {32'd2, 32'd2, 32'd2, 32'd3, 32'hFFFFFFFF};  exp_r[3] = 32'hFFFFFFFD;   exp_c[3] = 3'd2;
    for (int t = 0; t < 4; t++) begin
      do_txn(arrs[t], lat, r, c);
      tests_run++;
      if (lat != N) begin
        tests_failed++;
        $display("FAIL directed%0d_latency got=%0d required=%0d", t, lat, N);
      end
      tests_run++;
      if (r !== exp_r[t] || c !== exp_c[t]) begin
        tests_failed++;
        $display("FAIL directed%0d_result got=%h/%0d required=%h/%0d", t, r, c, exp_r[t], exp_c[t]);
      end
    end
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL directed_idle in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [N*W-1:0] a, b;
    logic [W-1:0]   ea, eb;
    logic [CW-1:0]  ca, cb;
    int k;
    a = {32'd13, 32'd11, 32'd7, 32'd2, 32'd5};
    b = rand_arr();
    model(a, ea, ca);
    model(b, eb, cb);
    bus.in_valid = 1'b1;
    bus.arr      = a;
    step();
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 100) begin
      step();
      k++;
    end
    tests_run++;
    if (k != N) begin
      tests_failed++;
      $display("FAIL bp_latency got=%0d required=%0d", k, N);
    end
    bus.in_valid = 1'b1;
    bus.arr      = b;
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (bus.result !== ea || bus.odd_count !== ca || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_hold%0d result=%h/%0d in_ready=%b out_valid=%b required %h/%0d 0 1",
                 i, bus.result, bus.odd_count, bus.in_ready, bus.out_valid, ea, ca);
      end
      step();
    end
    $display("[TB] txn backpressure held result=%h odd_count=%0d", bus.result, bus.odd_count);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
    end
    step();
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_accept busy=%b in_ready=%b required 1 0", bus.busy, bus.in_ready);
    end
    k = 0;
    while (!bus.out_valid && k < 100) begin
      step();
      k++;
    end
    tests_run++;
    if (k != N || bus.result !== eb || bus.odd_count !== cb) begin
      tests_failed++;
      $display("FAIL bp_second got=%h/%0d lat=%0d required %h/%0d lat=%0d",
               bus.result, bus.odd_count, k, eb, cb, N);
    end
    $display("[TB] txn backpressure second result=%h odd_count=%0d", bus.result, bus.odd_count);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0]  r;
    logic [CW-1:0] c;
    int lat;
    bus.in_valid = 1'b1;
    bus.arr      = {32'd7, 32'd7, 32'd7, 32'd7, 32'd7};
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.result !== '0 || bus.odd_count !== '0) begin
      tests_failed++;
      $display("FAIL midrun_reset in_ready=%b out_valid=%b busy=%b result=%h cnt=%0d required 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.result, bus.odd_count);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL midrun_no_valid%0d out_valid=%b required 0", i, bus.out_valid);
      end
    end
    rst = 1'b0;
    step();
    do_txn({32'd3, 32'd3, 32'd3, 32'd3, 32'd3}, lat, r, c);
    tests_run++;
    if (lat != N || r !== 32'd243 || c !== 3'd5) begin
      tests_failed++;
      $display("FAIL midrun_after got=%h/%0d lat=%0d required %h/%0d lat=%0d", r, c, lat, 32'd243, 5, N);
    end
  endtask

  task automatic test_back_to_back();
    logic [N*W-1:0] arrs [3];
    logic [W-1:0]   exp_r [3];
    logic [CW-1:0]  exp_c [3];
    int             acc_cyc [$];
    logic [W-1:0]   got_r [$];
    logic [CW-1:0]  got_c [$];
    int  sent;
    bit  acc_now;
    for (int i = 0; i < 3; i++) begin
      arrs[i] = rand_arr();
      model(arrs[i], exp_r[i], exp_c[i]);
    end
    sent          = 0;
    bus.in_valid  = 1'b1;
    bus.arr       = arrs[0];
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && got_r.size() < 3; cyc++) begin
      acc_now = bus.in_ready && bus.in_valid;
      if (bus.out_valid) begin
        got_r.push_back(bus.result);
        got_c.push_back(bus.odd_count);
        $display("[TB] txn b2b result=%h odd_count=%0d cycle=%0d", bus.result, bus.odd_count, cyc);
      end
      step();
      if (acc_now) begin
        acc_cyc.push_back(cyc);
        sent++;
        if (sent < 3) bus.arr = arrs[sent];
        else          bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tests_run++;
    if (got_r.size() != 3) begin
      tests_failed++;
      $display("FAIL b2b_count got=%0d required=3", got_r.size());
    end
    for (int i = 0; i < got_r.size() && i < 3; i++) begin
      tests_run++;
      if (got_r[i] !== exp_r[i] || got_c[i] !== exp_c[i]) begin
        tests_failed++;
        $display("FAIL b2b_result%0d got=%h/%0d required %h/%0d", i, got_r[i], got_c[i], exp_r[i], exp_c[i]);
      end
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      tests_run++;
      if (acc_cyc[i] - acc_cyc[i-1] != N + 2) begin
        tests_failed++;
        $display("FAIL b2b_spacing%0d got=%0d required=%0d", i, acc_cyc[i] - acc_cyc[i-1], N + 2);
      end
    end
  endtask

  task automatic test_random();
    logic [N*W-1:0] a;
    logic [W-1:0]   r, er;
    logic [CW-1:0]  c, ec;
    int lat;
    for (int t = 0; t < 12; t++) begin
      a = rand_arr();
      model(a, er, ec);
      do_txn(a, lat, r, c);
      tests_run++;
      if (lat != N || r !== er || c !== ec) begin
        tests_failed++;
        $display("FAIL random%0d got=%h/%0d lat=%0d required %h/%0d lat=%0d", t, r, c, lat, er, ec, N);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/odd_mult_seq.md
Name: odd_mult_seq

Overview:
- Sequential replacement for the combinational odd-element product over a packed array.
- Computes the product of all odd elements of a packed N-element, W-bit array using one shared W x W multiplier stage, one element per cycle.
- Input and output use valid/ready handshakes so the block sits between a producer of packed arrays and a consumer of results.
- Result semantics match the combinational version: start at 1, multiply by each odd element, product truncated to W bits.

Parameters:
- N, 5, number of elements in the packed array (N >= 1).
- W, 32, element and result width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer presents arr.
- in_ready  output  1  block can accept arr; high only in IDLE.
- arr  input  N*W  packed array; element i = arr[i*W +: W].
- out_valid  output  1  result and odd_count are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  W  truncated product of odd elements; 1 if there are none.
- odd_count  output  $clog2(N+1)  number of odd elements found.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, acc=0, result=0, odd_count=0, out_valid=0, busy=0. in_ready is decoded from state, so it is 1 while in reset.
- State IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture arr into an internal N*W register, acc=1, cnt=0, idx=0, go to RUN.
  - arr is don't-care after the accept edge.
- State RUN:
  - in_ready=0, busy=1.
  - Each edge examines element idx of the captured array. If its bit 0 is 1: acc <= (acc*elem)[W-1:0] and cnt <= cnt+1. Otherwise acc and cnt hold.
  - If idx==N-1: go to DONE and load result<=next acc and odd_count<=next cnt. Otherwise idx <= idx+1.
- State DONE:
  - out_valid=1; result and odd_count stay stable until the handshake.
  - On an edge with out_ready=1: go to IDLE, out_valid=0.
  - in_ready first rises the cycle after the output handshake; there is no same-cycle turnaround.
- Latency: accept edge E0, elements processed on E1..EN, out_valid high after EN. Output is available N cycles after accept.
- Throughput: one array per N+2 cycles with out_ready held high.
- Arithmetic:
  - Full 2W-bit product, low W bits kept; unsigned.
  - An element equal to 0 is even and never zeroes acc.
  - An odd product stays odd after truncation.
- Boundaries:
  - in_valid in RUN/DONE: ignored, nothing captured. The producer must hold it per valid/ready rules.
  - out_ready high outside DONE: no effect.
  - Reset mid-RUN or mid-DONE: in-flight array discarded, no out_valid pulse. The next accepted array computes correctly.
  - N=1: RUN lasts exactly one cycle.
  - idx never exceeds N-1; no wrap.

Decomposition:
- Package odd_mult_pkg:
  - state enum {IDLE, RUN, DONE}, 2 bits;
  - default constants N_DEF=5, W_DEF=32;
  - index-width helper IDX_W=$clog2(N).
- Sub-module odd_mult_step (combinational):
  - inputs acc[W], elem[W], cnt; outputs acc_next = elem[0] ? (acc*elem)[W-1:0] : acc, and cnt_next.
  - Isolates the shared multiplier so it can later be pipelined or shared between instances.

Test Plan:
- arr={9,7,5,3,1} (element 0 = 1), out_ready=1 -> out_valid exactly 5 cycles after accept; result=945, odd_count=5.
- arr all even {10,8,6,4,2} -> result=1, odd_count=0. Mixed {7,6,5,4,3} -> result=105, odd_count=3.
- Overflow: element0=0xFFFFFFFF, element1=3, others 2 -> result=0xFFFFFFFD, odd_count=2.
- Backpressure: out_ready=0 for 10 cycles in DONE while in_valid=1 with a new arr -> result stable, in_ready=0, new arr not captured. Release out_ready -> in_ready=1 next cycle, then the new arr is accepted and computed correctly.
- Reset asserted on the 3rd RUN cycle -> all outputs reset immediately, in_ready=1, no out_valid. The following transaction {3,3,3,3,3} yields 243, odd_count=5.
- Back-to-back: three arrays with in_valid and out_ready held high -> accepts spaced N+2 cycles apart, results returned in order.
